// File: rtl/cv32e40x_instr_aligner.sv
// Instruction aligner: buffers fetched words, re-aligns 16/32-bit instructions across
// word boundaries, drops responses of flushed fetch streams and throttles new requests.
module cv32e40x_instr_aligner #(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        trans_valid_i,
  input  logic        trans_ready_i,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_rdata_i,
  input  logic        resp_err_i,
  output logic        req_allowed_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_compressed_o,
  output logic        instr_err_o
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] head, head_nxt, tail;
  logic [AW:0]   tail_sum;
  logic [CW-1:0] cnt, out_cnt, drop_cnt;
  logic [CW:0]   occ;
  logic [31:0]   pc, rdata;
  logic [15:0]   half;
  entry_t        w0, w1;
  logic          valid, comp, err, fire, pop, push;

  // Ring buffer indices; DEPTH need not be a power of two
  always_comb begin
    head_nxt = (head == AW'(DEPTH - 1)) ? '0 : head + 1'b1;
    tail_sum = {1'b0, head} + (AW+1)'(cnt);
    tail     = (tail_sum >= (AW+1)'(DEPTH)) ? AW'(tail_sum - (AW+1)'(DEPTH)) : AW'(tail_sum);
    w0       = mem[head];
    w1       = mem[head_nxt];
  end

  always_comb begin
    half  = pc[1] ? w0.rdata[31:16] : w0.rdata[15:0];
    valid = 1'b0;
    comp  = 1'b0;
    err   = 1'b0;
    rdata = w0.rdata;
    if (w0.err) begin
      // Faulted head word: report at once, treated as a 4-byte slot
      valid = (cnt != '0);
      err   = 1'b1;
    end else if (half[1:0] != 2'b11) begin
      valid = (cnt != '0);
      comp  = 1'b1;
      rdata = {16'h0, half};
    end else if (!pc[1]) begin
      valid = (cnt != '0);
    end else begin
      valid = (cnt >= CW'(2));
      rdata = {w1.rdata[15:0], half};
      err   = w1.err;
    end
  end

  assign fire = valid && instr_ready_i;
  assign pop  = fire && (pc[1] || !comp);
  assign push = resp_valid_i && (drop_cnt == '0) && !branch_i;
  assign occ  = (CW+1)'(cnt) + (CW+1)'(out_cnt) - (CW+1)'(drop_cnt);

  assign req_allowed_o      = occ < (CW+1)'(DEPTH);
  assign instr_valid_o      = valid;
  assign instr_addr_o       = pc;
  assign instr_rdata_o      = valid ? rdata : '0;
  assign instr_compressed_o = valid & comp;
  assign instr_err_o        = valid & err;

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= {resp_rdata_i, resp_err_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      head     <= '0;
      pc       <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      case ({trans_valid_i && trans_ready_i, resp_valid_i})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
      if (branch_i) begin
        cnt      <= '0;
        head     <= '0;
        pc       <= branch_addr_i;
        drop_cnt <= out_cnt - CW'(resp_valid_i);
      end else begin
        if (resp_valid_i && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (fire) pc <= pc + (comp ? 32'd2 : 32'd4);
        if (pop) head <= head_nxt;
        case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && cnt == CW'(DEPTH) && !pop));
      assert (!(resp_valid_i && out_cnt == '0));
      assert (drop_cnt <= out_cnt);
    end
  end
endmodule

// File: tb/tb_cv32e40x_instr_aligner.sv
// Bench for cv32e40x_instr_aligner: directed scenarios plus a randomized run
// against a word-queue reference model.
module tb_cv32e40x_instr_aligner;
  localparam int DEPTH = 3;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } word_t;

  logic        clk = 1'b0, rst = 1'b1, branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0, resp_rdata_i = '0;
  logic        trans_valid_i = 1'b0, trans_ready_i = 1'b0, resp_valid_i = 1'b0;
  logic        resp_err_i = 1'b0, instr_ready_i = 1'b0;
  logic        req_allowed_o, instr_valid_o, instr_compressed_o, instr_err_o;
  logic [31:0] instr_rdata_o, instr_addr_o;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  cv32e40x_instr_aligner #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .trans_valid_i(trans_valid_i), .trans_ready_i(trans_ready_i),
    .resp_valid_i(resp_valid_i), .resp_rdata_i(resp_rdata_i), .resp_err_i(resp_err_i),
    .req_allowed_o(req_allowed_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .instr_rdata_o(instr_rdata_o),
    .instr_addr_o(instr_addr_o), .instr_compressed_o(instr_compressed_o),
    .instr_err_o(instr_err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branch_i = 0; trans_valid_i = 0; trans_ready_i = 0;
    resp_valid_i = 0; resp_err_i = 0; instr_ready_i = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic req(input int n);
    trans_valid_i = 1; trans_ready_i = 1;
    repeat (n) tick();
    trans_valid_i = 0; trans_ready_i = 0;
  endtask

  task automatic resp(input logic [31:0] d, input logic e);
    resp_valid_i = 1; resp_rdata_i = d; resp_err_i = e;
    tick();
    resp_valid_i = 0; resp_err_i = 0;
  endtask

  task automatic branch(input logic [31:0] a);
    branch_i = 1; branch_addr_i = a;
    tick();
    branch_i = 0;
  endtask

  task automatic test_reset();
    rst = 1; instr_ready_i = 1; trans_valid_i = 1; trans_ready_i = 1;
    tick(); tick();
    idle();
    n_chk++; if (instr_valid_o !== 1'b0) $display("FAIL reset_valid got %b exp 0", instr_valid_o); else n_pass++;
    n_chk++; if (instr_addr_o !== 32'h0) $display("FAIL reset_addr got %h exp 0", instr_addr_o); else n_pass++;
    n_chk++; if (instr_rdata_o !== 32'h0) $display("FAIL reset_rdata got %h exp 0", instr_rdata_o); else n_pass++;
    n_chk++; if (instr_compressed_o !== 1'b0) $display("FAIL reset_comp got %b exp 0", instr_compressed_o); else n_pass++;
    n_chk++; if (instr_err_o !== 1'b0) $display("FAIL reset_err got %b exp 0", instr_err_o); else n_pass++;
    n_chk++; if (req_allowed_o !== 1'b1) $display("FAIL reset_req_allowed got %b exp 1", req_allowed_o); else n_pass++;
    rst = 0;
  endtask

  task automatic test_aligned();
    do_reset();
    branch(32'h100);
    req(2);
    n_chk++; if (instr_valid_o !== 1'b0) $display("FAIL aligned_empty got %b exp 0", instr_valid_o); else n_pass++;
    resp(32'h00A00093, 0);
    n_chk++; if (instr_valid_o !== 1'b1) $display("FAIL aligned_latency got %b exp 1", instr_valid_o); else n_pass++;
    n_chk++; if (instr_rdata_o !== 32'h00A00093) $display("FAIL aligned_rdata0 got %h exp %h", instr_rdata_o, 32'h00A00093); else n_pass++;
    resp(32'h00100113, 0);
    instr_ready_i = 1;
    n_chk++; if (instr_addr_o !== 32'h100 || instr_compressed_o !== 1'b0) $display("FAIL aligned_addr0 got %h/%b exp 100/0", instr_addr_o, instr_compressed_o); else n_pass++;
    tick();
    n_chk++; if (instr_rdata_o !== 32'h00100113 || instr_addr_o !== 32'h104) $display("FAIL aligned_instr1 got %h@%h exp 00100113@104", instr_rdata_o, instr_addr_o); else n_pass++;
    tick();
    instr_ready_i = 0;
    n_chk++; if (instr_valid_o !== 1'b0 || instr_addr_o !== 32'h108) $display("FAIL aligned_drain got %b@%h exp 0@108", instr_valid_o, instr_addr_o); else n_pass++;
  endtask

  task automatic test_compressed();
    do_reset();
    branch(32'h200);
    req(1);
    resp(32'h40014501, 0);
    n_chk++; if (instr_rdata_o !== 32'h4501 || instr_addr_o !== 32'h200 || instr_compressed_o !== 1'b1) $display("FAIL comp_lo got %h@%h c=%b exp 4501@200 c=1", instr_rdata_o, instr_addr_o, instr_compressed_o); else n_pass++;
    instr_ready_i = 1;
    tick();
    n_chk++; if (instr_valid_o !== 1'b1 || instr_rdata_o !== 32'h4001 || instr_addr_o !== 32'h202) $display("FAIL comp_hi got %b %h@%h exp 1 4001@202", instr_valid_o, instr_rdata_o, instr_addr_o); else n_pass++;
    tick();
    instr_ready_i = 0;
    n_chk++; if (instr_valid_o !== 1'b0 || instr_addr_o !== 32'h204) $display("FAIL comp_pop got %b@%h exp 0@204", instr_valid_o, instr_addr_o); else n_pass++;
  endtask

  task automatic test_straddle();
    do_reset();
    branch(32'h300);
    req(2);
    resp(32'h00934501, 0);
    n_chk++; if (instr_rdata_o !== 32'h4501 || instr_compressed_o !== 1'b1) $display("FAIL strad_c got %h c=%b exp 4501 c=1", instr_rdata_o, instr_compressed_o); else n_pass++;
    instr_ready_i = 1;
    tick();
    instr_ready_i = 0;
    n_chk++; if (instr_valid_o !== 1'b0 || instr_addr_o !== 32'h302) $display("FAIL strad_hold got %b@%h exp 0@302", instr_valid_o, instr_addr_o); else n_pass++;
    tick();
    n_chk++; if (instr_valid_o !== 1'b0) $display("FAIL strad_hold2 got %b exp 0", instr_valid_o); else n_pass++;
    resp(32'h123400A0, 0);
    n_chk++; if (instr_valid_o !== 1'b1 || instr_rdata_o !== 32'h00A00093 || instr_compressed_o !== 1'b0) $display("FAIL strad_join got %b %h c=%b exp 1 00A00093 c=0", instr_valid_o, instr_rdata_o, instr_compressed_o); else n_pass++;
    instr_ready_i = 1;
    tick();
    n_chk++; if (instr_rdata_o !== 32'h1234 || instr_addr_o !== 32'h306 || instr_compressed_o !== 1'b1) $display("FAIL strad_tail got %h@%h exp 1234@306", instr_rdata_o, instr_addr_o); else n_pass++;
    tick();
    instr_ready_i = 0;
    n_chk++; if (instr_valid_o !== 1'b0 || instr_addr_o !== 32'h308) $display("FAIL strad_end got %b@%h exp 0@308", instr_valid_o, instr_addr_o); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    branch(32'h500);
    req(2);
    branch_i = 1; branch_addr_i = 32'h600;
    resp_valid_i = 1; resp_rdata_i = 32'hDEAD0001;
    tick();
    idle();
    n_chk++; if (instr_valid_o !== 1'b0 || instr_addr_o !== 32'h600) $display("FAIL flush_redirect got %b@%h exp 0@600", instr_valid_o, instr_addr_o); else n_pass++;
    n_chk++; if (req_allowed_o !== 1'b1) $display("FAIL flush_req_allowed got %b exp 1", req_allowed_o); else n_pass++;
    req(1);
    resp(32'hBAD00013, 0);
    n_chk++; if (instr_valid_o !== 1'b0) $display("FAIL flush_drop got %b exp 0", instr_valid_o); else n_pass++;
    resp(32'h00B00513, 0);
    n_chk++; if (instr_valid_o !== 1'b1 || instr_rdata_o !== 32'h00B00513 || instr_addr_o !== 32'h600) $display("FAIL flush_keep got %b %h@%h exp 1 00B00513@600", instr_valid_o, instr_rdata_o, instr_addr_o); else n_pass++;
  endtask

  task automatic test_error();
    do_reset();
    branch(32'h402);
    req(1);
    resp(32'hFFFF_FFFF, 1);
    n_chk++; if (instr_valid_o !== 1'b1 || instr_err_o !== 1'b1 || instr_compressed_o !== 1'b0) $display("FAIL err_head got v=%b e=%b c=%b exp 1 1 0", instr_valid_o, instr_err_o, instr_compressed_o); else n_pass++;
    instr_ready_i = 1;
    tick();
    instr_ready_i = 0;
    n_chk++; if (instr_valid_o !== 1'b0 || instr_addr_o !== 32'h406) $display("FAIL err_consume got %b@%h exp 0@406", instr_valid_o, instr_addr_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] w [3];
    int issued = 0;
    do_reset();
    branch(32'h700);
    for (int i = 0; i < 5; i++) begin
      trans_valid_i = req_allowed_o; trans_ready_i = 1;
      if (req_allowed_o) issued++;
      tick();
    end
    idle();
    n_chk++; if (issued != 3 || req_allowed_o !== 1'b0) $display("FAIL bp_throttle got issued=%0d ra=%b exp 3 0", issued, req_allowed_o); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      w[i] = 32'h00000013 | (i << 20);
      resp(w[i], 0);
    end
    n_chk++; if (instr_rdata_o !== w[0] || req_allowed_o !== 1'b0) $display("FAIL bp_full got %h ra=%b exp %h 0", instr_rdata_o, req_allowed_o, w[0]); else n_pass++;
    tick(); tick();
    n_chk++; if (instr_valid_o !== 1'b1 || instr_rdata_o !== w[0] || instr_addr_o !== 32'h700) $display("FAIL bp_stable got %b %h@%h exp 1 %h@700", instr_valid_o, instr_rdata_o, instr_addr_o, w[0]); else n_pass++;
    instr_ready_i = 1;
    tick();
    instr_ready_i = 0;
    n_chk++; if (instr_rdata_o !== w[1] || instr_addr_o !== 32'h704 || req_allowed_o !== 1'b1) $display("FAIL bp_release got %h@%h ra=%b exp %h@704 1", instr_rdata_o, instr_addr_o, req_allowed_o, w[1]); else n_pass++;
    rst = 1;
    tick();
    rst = 0;
    n_chk++; if (instr_valid_o !== 1'b0 || instr_addr_o !== 32'h0 || req_allowed_o !== 1'b1) $display("FAIL midop_reset got %b@%h ra=%b exp 0@0 1", instr_valid_o, instr_addr_o, req_allowed_o); else n_pass++;
  endtask

  task automatic test_random();
    word_t       q[$];
    logic [31:0] mpc, erd;
    logic [15:0] h;
    logic        ev, ec, ee, era, skip_rd;
    int          out, drop;
    do_reset();
    mpc = 0; out = 0; drop = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ev = 0; ec = 0; ee = 0; erd = 0; skip_rd = 0;
      if (q.size() > 0) begin
        h = mpc[1] ? q[0].d[31:16] : q[0].d[15:0];
        if (q[0].e) begin ev = 1; ee = 1; skip_rd = 1; end
        else if (h[1:0] != 2'b11) begin ev = 1; ec = 1; erd = {16'h0, h}; end
        else if (!mpc[1]) begin ev = 1; erd = q[0].d; end
        else if (q.size() > 1) begin ev = 1; erd = {q[1].d[15:0], h}; ee = q[1].e; end
      end
      era = (q.size() + out - drop) < DEPTH;
      n_chk++; if (instr_valid_o !== ev) $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, instr_valid_o, ev); else n_pass++;
      n_chk++; if (instr_addr_o !== mpc) $display("FAIL rnd_addr cyc %0d got %h exp %h", cyc, instr_addr_o, mpc); else n_pass++;
      n_chk++; if (req_allowed_o !== era) $display("FAIL rnd_req_allowed cyc %0d got %b exp %b", cyc, req_allowed_o, era); else n_pass++;
      if (ev) begin
        n_chk++; if (instr_compressed_o !== ec || instr_err_o !== ee) $display("FAIL rnd_flags cyc %0d got c=%b e=%b exp c=%b e=%b", cyc, instr_compressed_o, instr_err_o, ec, ee); else n_pass++;
        if (!skip_rd) begin
          n_chk++; if (instr_rdata_o !== erd) $display("FAIL rnd_rdata cyc %0d got %h exp %h", cyc, instr_rdata_o, erd); else n_pass++;
        end
      end
      branch_i      = ($urandom_range(0, 15) == 0);
      branch_addr_i = $urandom & 32'h0000_FFFE;
      trans_valid_i = era && (out < DEPTH) && ($urandom_range(0, 1) == 1);
      trans_ready_i = ($urandom_range(0, 3) != 0);
      resp_valid_i  = (out > 0) && ($urandom_range(0, 1) == 1);
      resp_rdata_i  = $urandom;
      resp_err_i    = ($urandom_range(0, 9) == 0);
      instr_ready_i = ($urandom_range(0, 2) != 0);
      if (branch_i) begin
        q.delete();
        mpc  = branch_addr_i;
        drop = out - int'(resp_valid_i);
      end else begin
        if (ev && instr_ready_i) begin
          if (mpc[1] || !ec) void'(q.pop_front());
          mpc = mpc + (ec ? 32'd2 : 32'd4);
        end
        if (resp_valid_i) begin
          if (drop > 0) drop--;
          else q.push_back('{resp_rdata_i, resp_err_i});
        end
      end
      out = out + int'(trans_valid_i && trans_ready_i) - int'(resp_valid_i);
      tick();
    end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_aligned();
    test_compressed();
    test_straddle();
    test_flush();
    test_error();
    test_backpressure();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
